bouncing_box: RTL and testbench



---
 rtl/vga_pkg.sv | 29 ++
 rtl/bouncing_box_if.sv | 14 +
 rtl/box_axis.sv | 51 +++++
 rtl/bouncing_box.sv | 111 +++++++++++
 tb/tb_bouncing_box.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing and colour definitions for the pixel sources and videosyncs.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

  localparam int R_W     = 3;
  localparam int G_W     = 3;
  localparam int B_W     = 2;
  localparam int COLOR_W = R_W + G_W + B_W;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb_t;

  localparam logic [COLOR_W-1:0] COLOR_BLACK    = 8'b000_000_00;
  localparam logic [COLOR_W-1:0] COLOR_RED      = 8'b111_000_00;
  localparam logic [COLOR_W-1:0] COLOR_DIM_BLUE = 8'b000_000_01;

  // Half-open span test [lo, lo+len) with one guard bit so lo+len never wraps.
  function automatic logic in_span(input logic [9:0] p, input logic [9:0] lo, input int len);
    logic [10:0] hi;
    hi = {1'b0, lo} + 11'(len);
    return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < hi);
  endfunction

endpackage

// File: rtl/bouncing_box_if.sv
// Pixel bus between videosyncs (master: counters, vsync) and a pixel source (slave: colour).
interface bouncing_box_if;
  import vga_pkg::*;

  logic [9:0]     xpos;
  logic [9:0]     ypos;
  logic           vsync;
  logic [R_W-1:0] red;
  logic [G_W-1:0] green;
  logic [B_W-1:0] blue;

  modport master (output xpos, ypos, vsync, input red, green, blue);
  modport slave  (input xpos, ypos, vsync, output red, green, blue);
endinterface

// File: rtl/box_axis.sv
// One axis of the bouncing box: position, direction and clamp/reflect on each move.
module box_axis #(
  parameter int LIM  = 608,
  parameter int INIT = 100,
  parameter int STEP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move,
  output logic [9:0] pos,
  output logic       dir,
  output logic       hit
);

  logic [10:0] up_w;
  logic [9:0]  pos_next;

  assign up_w = {1'b0, pos} + 11'(STEP);

  // hit reflects what the next move would do from the current state.
  always_comb begin
    hit      = 1'b0;
    pos_next = pos;
    if (dir) begin
      if (up_w >= 11'(LIM)) begin
        hit      = 1'b1;
        pos_next = 10'(LIM);
      end else begin
        pos_next = up_w[9:0];
      end
    end else begin
      if ({1'b0, pos} <= 11'(STEP)) begin
        hit      = 1'b1;
        pos_next = '0;
      end else begin
        pos_next = pos - 10'(STEP);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= 10'(INIT);
      dir <= 1'b1;
    end else if (move) begin
      pos <= pos_next;
      dir <= hit ? ~dir : dir;
    end
  end

endmodule

// File: rtl/bouncing_box.sv
// Pixel source drawing a solid rectangle that bounces around the active area,
// repositioned only at the start of vsync so a frame never tears.
module bouncing_box
  import vga_pkg::*;
#(
  parameter int                 H_ACTIVE  = VGA_H_ACTIVE,
  parameter int                 V_ACTIVE  = VGA_V_ACTIVE,
  parameter int                 BOX_W     = 32,
  parameter int                 BOX_H     = 24,
  parameter int                 X_INIT    = 100,
  parameter int                 Y_INIT    = 100,
  parameter int                 STEP      = 2,
  parameter int                 FRAME_DIV = 1,
  parameter logic [COLOR_W-1:0] BOX_COLOR = COLOR_RED,
  parameter logic [COLOR_W-1:0] BG_COLOR  = COLOR_DIM_BLUE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  bouncing_box_if.slave        vid,
  output logic                 frame_tick,
  output logic                 bounce,
  output logic [7:0]           bounce_cnt
);

  localparam int         X_LIM    = H_ACTIVE - BOX_W;
  localparam int         Y_LIM    = V_ACTIVE - BOX_H;
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  if (X_INIT < 0 || X_INIT > X_LIM) begin : g_bad_x_init
    $error("bouncing_box: X_INIT out of range");
  end
  if (Y_INIT < 0 || Y_INIT > Y_LIM) begin : g_bad_y_init
    $error("bouncing_box: Y_INIT out of range");
  end
  if (STEP <= 0 || STEP >= BOX_W || STEP >= BOX_H) begin : g_bad_step
    $error("bouncing_box: STEP out of range");
  end
  if (FRAME_DIV < 1 || FRAME_DIV > 255) begin : g_bad_div
    $error("bouncing_box: FRAME_DIV out of range");
  end

  logic       vs_d;
  logic [7:0] div_cnt;
  logic       move;
  logic       any_hit;
  logic [9:0] box_x, box_y;
  logic       dir_x, dir_y;
  logic       hit_x, hit_y;
  rgb_t       pix_next;
  rgb_t       pix_p1;

  assign move    = frame_tick && enable && (div_cnt == DIV_LAST);
  assign any_hit = hit_x || hit_y;

  box_axis #(.LIM(X_LIM), .INIT(X_INIT), .STEP(STEP)) u_axis_x (
    .clk  (clk),
    .rst  (rst),
    .move (move),
    .pos  (box_x),
    .dir  (dir_x),
    .hit  (hit_x)
  );

  box_axis #(.LIM(Y_LIM), .INIT(Y_INIT), .STEP(STEP)) u_axis_y (
    .clk  (clk),
    .rst  (rst),
    .move (move),
    .pos  (box_y),
    .dir  (dir_y),
    .hit  (hit_y)
  );

  // Frame tick, divider and bounce bookkeeping; a corner hit counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d       <= 1'b1;
      frame_tick <= 1'b0;
      div_cnt    <= '0;
      bounce     <= 1'b0;
      bounce_cnt <= '0;
    end else begin
      vs_d       <= vid.vsync;
      frame_tick <= vs_d && !vid.vsync;
      bounce     <= move && any_hit;
      if (move && any_hit) bounce_cnt <= bounce_cnt + 8'd1;
      if (frame_tick && enable) div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
    end
  end

  always_comb begin
    pix_next = rgb_t'(COLOR_BLACK);
    if ({1'b0, vid.xpos} < 11'(H_ACTIVE) && {1'b0, vid.ypos} < 11'(V_ACTIVE)) begin
      if (in_span(vid.xpos, box_x, BOX_W) && in_span(vid.ypos, box_y, BOX_H))
        pix_next = rgb_t'(BOX_COLOR);
      else
        pix_next = rgb_t'(BG_COLOR);
    end
  end

  // Render stage boundary: colour for the counters sampled on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pix_p1 <= rgb_t'(COLOR_BLACK);
    else     pix_p1 <= pix_next;
  end

  assign vid.red   = pix_p1.r;
  assign vid.green = pix_p1.g;
  assign vid.blue  = pix_p1.b;

endmodule

// File: tb/tb_bouncing_box.sv
// Directed bench for bouncing_box: four instances cover default motion, edge
// bounce, corner bounce and the frame divider from one shared stimulus stream.
module tb_bouncing_box;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       vsync;
  logic [9:0] xpos, ypos;

  logic       ft_a, ft_b, ft_c, ft_d;
  logic       bn_a, bn_b, bn_c, bn_d;
  logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #20 clk = ~clk;

  bouncing_box_if va ();
  bouncing_box_if vb ();
  bouncing_box_if vc ();
  bouncing_box_if vd ();

  assign va.xpos = xpos;  assign va.ypos = ypos;  assign va.vsync = vsync;
  assign vb.xpos = xpos;  assign vb.ypos = ypos;  assign vb.vsync = vsync;
  assign vc.xpos = xpos;  assign vc.ypos = ypos;  assign vc.vsync = vsync;
  assign vd.xpos = xpos;  assign vd.ypos = ypos;  assign vd.vsync = vsync;

  bouncing_box dut_a (
    .clk(clk), .rst(rst), .enable(enable), .vid(va.slave),
    .frame_tick(ft_a), .bounce(bn_a), .bounce_cnt(cnt_a)
  );

  bouncing_box #(.X_INIT(606)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .vid(vb.slave),
    .frame_tick(ft_b), .bounce(bn_b), .bounce_cnt(cnt_b)
  );

  bouncing_box #(.X_INIT(607), .Y_INIT(455)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .vid(vc.slave),
    .frame_tick(ft_c), .bounce(bn_c), .bounce_cnt(cnt_c)
  );

  bouncing_box #(.FRAME_DIV(3)) dut_d (
    .clk(clk), .rst(rst), .enable(enable), .vid(vd.slave),
    .frame_tick(ft_d), .bounce(bn_d), .bounce_cnt(cnt_d)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [7:0] color_a();
    return {va.red, va.green, va.blue};
  endfunction

  task automatic render_check(input string tag, input int x, input int y, input logic [7:0] exp);
    @(negedge clk);
    xpos = 10'(x);
    ypos = 10'(y);
    @(negedge clk);
    check_eq(tag, 32'(color_a()), 32'(exp));
  endtask

  // After this returns, frame_tick is high for the current cycle.
  task automatic vs_fall();
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic vs_rise();
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int ticks;
    rst    = 1'b1;
    enable = 1'b1;
    vsync  = 1'b1;
    xpos   = '0;
    ypos   = '0;
    repeat (3) @(negedge clk);

    check_eq("rst_color",   32'(color_a()), 32'h0);
    check_eq("rst_box_x",   32'(dut_a.box_x), 32'd100);
    check_eq("rst_box_y",   32'(dut_a.box_y), 32'd100);
    check_eq("rst_dir",     32'({dut_a.dir_x, dut_a.dir_y}), 32'b11);
    check_eq("rst_cnt",     32'(cnt_a), 32'd0);
    check_eq("rst_tick",    32'(ft_a), 32'd0);
    rst = 1'b0;

    render_check("render_box_tl",   100, 100, 8'b111_000_00);
    render_check("render_box_br",   131, 123, 8'b111_000_00);
    render_check("render_right",    132, 100, 8'b000_000_01);
    render_check("render_left",      99, 110, 8'b000_000_01);
    render_check("render_below",    110, 124, 8'b000_000_01);
    render_check("render_h_blank",  700, 100, 8'h00);
    render_check("render_v_blank",  100, 490, 8'h00);
    render_check("render_h_edge",   640,  10, 8'h00);
    render_check("render_last_px",  639, 479, 8'b000_000_01);

    // Tick 1
    vs_fall();
    check_eq("t1_tick_hi", 32'(ft_a), 32'd1);
    @(negedge clk);
    check_eq("t1_tick_lo", 32'(ft_a), 32'd0);
    check_eq("t1_a_x",     32'(dut_a.box_x), 32'd102);
    check_eq("t1_a_y",     32'(dut_a.box_y), 32'd102);
    check_eq("t1_b_x",     32'(dut_b.box_x), 32'd608);
    check_eq("t1_b_dir",   32'(dut_b.dir_x), 32'd0);
    check_eq("t1_b_bounce",32'(bn_b), 32'd1);
    check_eq("t1_b_cnt",   32'(cnt_b), 32'd1);
    check_eq("t1_a_bounce",32'(bn_a), 32'd0);
    check_eq("t1_c_x",     32'(dut_c.box_x), 32'd608);
    check_eq("t1_c_y",     32'(dut_c.box_y), 32'd456);
    check_eq("t1_c_dir",   32'({dut_c.dir_x, dut_c.dir_y}), 32'b00);
    check_eq("t1_c_bounce",32'(bn_c), 32'd1);
    check_eq("t1_c_cnt",   32'(cnt_c), 32'd1);
    check_eq("t1_d_div",   32'(dut_d.div_cnt), 32'd1);
    check_eq("t1_d_x",     32'(dut_d.box_x), 32'd100);
    @(negedge clk);
    check_eq("t1_b_pulse_end", 32'(bn_b), 32'd0);

    ticks = 0;
    repeat (1600) begin
      @(negedge clk);
      if (ft_a) ticks++;
    end
    check_eq("hold_low_no_tick", 32'(ticks), 32'd0);
    check_eq("hold_low_x",       32'(dut_a.box_x), 32'd102);
    vs_rise();

    // Tick 2
    vs_fall();
    @(negedge clk);
    check_eq("t2_a_x",      32'(dut_a.box_x), 32'd104);
    check_eq("t2_b_x",      32'(dut_b.box_x), 32'd606);
    check_eq("t2_b_bounce", 32'(bn_b), 32'd0);
    check_eq("t2_b_cnt",    32'(cnt_b), 32'd1);
    check_eq("t2_c_x",      32'(dut_c.box_x), 32'd606);
    check_eq("t2_c_y",      32'(dut_c.box_y), 32'd454);
    check_eq("t2_c_cnt",    32'(cnt_c), 32'd1);
    check_eq("t2_d_div",    32'(dut_d.div_cnt), 32'd2);
    check_eq("t2_d_x",      32'(dut_d.box_x), 32'd100);
    vs_rise();

    // Ticks 3..10: divider instance moves only on every third tick
    for (int t = 3; t <= 10; t++) begin
      vs_fall();
      @(negedge clk);
      check_eq($sformatf("div_t%0d_d_x", t), 32'(dut_d.box_x), 32'(100 + 2 * (t / 3)));
      check_eq($sformatf("div_t%0d_d_cnt", t), 32'(dut_d.div_cnt), 32'(t % 3));
      check_eq($sformatf("div_t%0d_a_x", t), 32'(dut_a.box_x), 32'(100 + 2 * t));
      vs_rise();
    end

    // Freeze: four ticks with motion disabled
    enable = 1'b0;
    ticks  = 0;
    repeat (4) begin
      vs_fall();
      if (ft_a) ticks++;
      @(negedge clk);
      vs_rise();
    end
    check_eq("freeze_ticks",  32'(ticks), 32'd4);
    check_eq("freeze_a_x",    32'(dut_a.box_x), 32'd120);
    check_eq("freeze_a_y",    32'(dut_a.box_y), 32'd120);
    check_eq("freeze_d_x",    32'(dut_d.box_x), 32'd106);
    check_eq("freeze_d_div",  32'(dut_d.div_cnt), 32'd1);
    enable = 1'b1;

    vs_fall();
    @(negedge clk);
    check_eq("resume_a_x",   32'(dut_a.box_x), 32'd122);
    check_eq("resume_d_div", 32'(dut_d.div_cnt), 32'd2);
    vs_rise();

    // Asynchronous reset mid-line with the box on screen
    render_check("pre_rst_color", 130, 130, 8'b111_000_00);
    check_eq("pre_rst_c_cnt", 32'(cnt_c), 32'd1);
    #5;
    rst = 1'b1;
    #1;
    check_eq("async_rst_color", 32'(color_a()), 32'h0);
    check_eq("async_rst_a_x",   32'(dut_a.box_x), 32'd100);
    check_eq("async_rst_a_y",   32'(dut_a.box_y), 32'd100);
    check_eq("async_rst_dir",   32'({dut_a.dir_x, dut_a.dir_y}), 32'b11);
    check_eq("async_rst_c_cnt", 32'(cnt_c), 32'd0);
    check_eq("async_rst_d_div", 32'(dut_d.div_cnt), 32'd0);
    check_eq("async_rst_b_dir", 32'(dut_b.dir_x), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
